// File: rtl/snake_pkg.sv
// Shared definitions for the snake game control path: scheduler state
// encoding, turn direction codes and default debounce width.
package snake_pkg;

    typedef enum logic [1:0] {
        TS_IDLE = 2'd0,
        TS_RUN  = 2'd1,
        TS_HALT = 2'd2
    } ts_state_t;

    localparam logic TURN_LEFT  = 1'b0;
    localparam logic TURN_RIGHT = 1'b1;

    localparam int DEFAULT_DEBOUNCE_BIT   = 18;
    localparam int DEFAULT_FIFO_DEPTH_BIT = 1;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus stability counter for one active-low key;
// emits a one-cycle press pulse on each accepted 1->0 transition.
module key_debouncer #(
    parameter int DEBOUNCE_BIT = 18
) (
    input  logic clock_25,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam logic [DEBOUNCE_BIT-1:0] COUNT_MAX = '1;

    logic                    sync_1;
    logic                    sync_2;
    logic                    level;
    logic [DEBOUNCE_BIT-1:0] count;

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync_2 == level) begin
                count <= '0;
            end else if (count == COUNT_MAX) begin
                level <= sync_2;
                count <= '0;
                press <= ~sync_2;
            end else begin
                count <= count + DEBOUNCE_BIT'(1);
            end
        end
    end

endmodule

// File: rtl/turn_request_scheduler.sv
// Turns debounced KEY2/KEY3 presses into queued turn requests and releases
// at most one per game_tik as a single-cycle turn_right/turn_left pulse.
module turn_request_scheduler
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_BIT   = DEFAULT_DEBOUNCE_BIT,
    parameter int FIFO_DEPTH_BIT = DEFAULT_FIFO_DEPTH_BIT
) (
    input  logic                    clock_25,
    input  logic                    reset,
    input  logic                    key_right_n,
    input  logic                    key_left_n,
    input  logic                    game_tik,
    input  logic                    start,
    input  logic                    game_over,
    input  logic                    sync_reset,
    output logic                    turn_right,
    output logic                    turn_left,
    output logic [FIFO_DEPTH_BIT:0] pending_count,
    output logic                    overflow
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BIT;
    localparam int PW    = FIFO_DEPTH_BIT + 1;

    logic press_right;
    logic press_left;

    key_debouncer #(.DEBOUNCE_BIT(DEBOUNCE_BIT)) u_key_right (
        .clock_25 (clock_25),
        .reset    (reset),
        .key_n    (key_right_n),
        .press    (press_right)
    );

    key_debouncer #(.DEBOUNCE_BIT(DEBOUNCE_BIT)) u_key_left (
        .clock_25 (clock_25),
        .reset    (reset),
        .key_n    (key_left_n),
        .press    (press_left)
    );

    ts_state_t        state;
    ts_state_t        state_next;
    logic [DEPTH-1:0] fifo_mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_next;
    logic [PW-1:0]    rd_ptr_next;
    logic             fifo_empty;
    logic             fifo_full;
    logic             head_dir;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                        (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign head_dir   = fifo_mem[rd_ptr[PW-2:0]];

    // Push is a fire-and-forget request (no back-pressure to the keys): it is
    // accepted when a slot is free after this cycle's pop, otherwise dropped.
    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        drop       = 1'b0;
        if (sync_reset) begin
            state_next = TS_IDLE;
        end else begin
            push_req = (state == TS_RUN) && (press_right ^ press_left);
            pop      = (state == TS_RUN) && game_tik && !fifo_empty;
            push     = push_req && (!fifo_full || pop);
            drop     = push_req && fifo_full && !pop;
            case (state)
                TS_IDLE: if (start && !game_over) state_next = TS_RUN;
                TS_RUN:  if (game_over) state_next = TS_HALT;
                TS_HALT: state_next = TS_HALT;
                default: state_next = TS_IDLE;
            endcase
        end
        wr_ptr_next = push ? wr_ptr + PW'(1) : wr_ptr;
        rd_ptr_next = pop  ? rd_ptr + PW'(1) : rd_ptr;
    end

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            state         <= TS_IDLE;
            fifo_mem      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pending_count <= '0;
            turn_right    <= 1'b0;
            turn_left     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state <= state_next;
            if (sync_reset) begin
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                pending_count <= '0;
                turn_right    <= 1'b0;
                turn_left     <= 1'b0;
                overflow      <= 1'b0;
            end else begin
                wr_ptr        <= wr_ptr_next;
                rd_ptr        <= rd_ptr_next;
                pending_count <= wr_ptr_next - rd_ptr_next;
                turn_right    <= pop && (head_dir == TURN_RIGHT);
                turn_left     <= pop && (head_dir == TURN_LEFT);
                if (drop) overflow <= 1'b1;
                // When full with a pop, the write lands in the slot being read.
                if (push) fifo_mem[wr_ptr[PW-2:0]] <= press_right ? TURN_RIGHT : TURN_LEFT;
            end
        end
    end

endmodule

// File: tb/tb_turn_request_scheduler.sv
// Bench for turn_request_scheduler with a 16-cycle debounce: table-driven
// press/tik scenarios, hand-written corner sequences and random stimulus.
module tb_turn_request_scheduler;

    localparam int DB     = 4;
    localparam int FB     = 1;
    localparam int DEPTH  = 2;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic          clock_25    = 1'b0;
    logic          reset       = 1'b1;
    logic          key_right_n = 1'b1;
    logic          key_left_n  = 1'b1;
    logic          game_tik    = 1'b0;
    logic          start       = 1'b0;
    logic          game_over   = 1'b0;
    logic          sync_reset  = 1'b0;
    logic          turn_right;
    logic          turn_left;
    logic [FB:0]   pending_count;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int n_r     = 0;
    int n_l     = 0;
    int pend_peak = 0;

    turn_request_scheduler #(.DEBOUNCE_BIT(DB), .FIFO_DEPTH_BIT(FB)) dut (
        .clock_25      (clock_25),
        .reset         (reset),
        .key_right_n   (key_right_n),
        .key_left_n    (key_left_n),
        .game_tik      (game_tik),
        .start         (start),
        .game_over     (game_over),
        .sync_reset    (sync_reset),
        .turn_right    (turn_right),
        .turn_left     (turn_left),
        .pending_count (pending_count),
        .overflow      (overflow)
    );

    always #20 clock_25 = ~clock_25;

    // Reference model: a key level is accepted once the last 16 synchronised
    // samples all disagree with the current level; requests live in a queue.
    int   m_q[$];
    int   m_state = M_IDLE;
    int   m_d;
    logic m_tr = 1'b0, m_tl = 1'b0, m_ovf = 1'b0;
    logic m_pr = 1'b0, m_pl = 1'b0;
    logic db_r = 1'b1, db_l = 1'b1;
    logic hist_r[18] = '{default: 1'b1};
    logic hist_l[18] = '{default: 1'b1};

    function automatic logic all_differ(input logic h[18], input logic v);
        for (int i = 2; i < 18; i++) if (h[i] == v) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_state = M_IDLE;
            m_tr = 1'b0; m_tl = 1'b0; m_ovf = 1'b0;
            m_pr = 1'b0; m_pl = 1'b0;
            db_r = 1'b1; db_l = 1'b1;
            for (int i = 0; i < 18; i++) begin
                hist_r[i] = 1'b1;
                hist_l[i] = 1'b1;
            end
        end else begin
            m_tr = 1'b0; m_tl = 1'b0;
            if (sync_reset) begin
                m_q.delete();
                m_ovf = 1'b0;
                m_state = M_IDLE;
            end else begin
                if (m_state == M_RUN && game_tik && m_q.size() > 0) begin
                    m_d = m_q.pop_front();
                    m_tr = (m_d == 1);
                    m_tl = (m_d == 0);
                end
                if (m_state == M_RUN && m_pr != m_pl) begin
                    if (m_q.size() < DEPTH) m_q.push_back(m_pr ? 1 : 0);
                    else m_ovf = 1'b1;
                end
                case (m_state)
                    M_IDLE: if (start && !game_over) m_state = M_RUN;
                    M_RUN:  if (game_over) m_state = M_HALT;
                    default: ;
                endcase
            end
            for (int i = 17; i > 0; i--) begin
                hist_r[i] = hist_r[i-1];
                hist_l[i] = hist_l[i-1];
            end
            hist_r[0] = key_right_n;
            hist_l[0] = key_left_n;
            m_pr = 1'b0;
            m_pl = 1'b0;
            if (all_differ(hist_r, db_r)) begin
                db_r = ~db_r;
                m_pr = (db_r == 1'b0);
            end
            if (all_differ(hist_l, db_l)) begin
                db_l = ~db_l;
                m_pl = (db_l == 1'b0);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        n_tests++;
        if (turn_right !== m_tr || turn_left !== m_tl || overflow !== m_ovf ||
            pending_count !== (FB+1)'(m_q.size())) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t got tr=%b tl=%b pend=%0d ovf=%b expected tr=%b tl=%b pend=%0d ovf=%b",
                     $time, turn_right, turn_left, pending_count, overflow,
                     m_tr, m_tl, m_q.size(), m_ovf);
        end
    endtask

    task automatic step();
        @(negedge clock_25);
        model_check();
        if (turn_right === 1'b1) n_r++;
        if (turn_left === 1'b1) n_l++;
        if (int'(pending_count) > pend_peak) pend_peak = int'(pending_count);
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic press(input bit right);
        if (right) key_right_n = 1'b0;
        else key_left_n = 1'b0;
        cycles(25);
        key_right_n = 1'b1;
        key_left_n  = 1'b1;
        cycles(25);
    endtask

    task automatic tik();
        game_tik = 1'b1;
        step();
        game_tik = 1'b0;
        cycles(3);
    endtask

    task automatic do_sync_reset();
        sync_reset = 1'b1;
        step();
        sync_reset = 1'b0;
    endtask

    task automatic begin_run();
        start = 1'b1;
        game_over = 1'b0;
        do_sync_reset();
        step();
    endtask

    typedef struct {
        int n_right;
        int n_left;
        int n_tik;
        int exp_pend;
        int exp_ovf;
        int exp_r;
        int exp_l;
        int exp_pend_after;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base_r, base_l;

        vecs[0] = '{1, 0, 1, 1, 0, 1, 0, 0};
        vecs[1] = '{1, 1, 2, 2, 0, 1, 1, 0};
        vecs[2] = '{3, 0, 2, 2, 1, 2, 0, 0};
        vecs[3] = '{0, 2, 3, 2, 0, 0, 2, 0};
        vecs[4] = '{2, 2, 2, 2, 1, 2, 0, 0};
        vecs[5] = '{0, 1, 0, 1, 0, 0, 0, 1};

        repeat (3) @(negedge clock_25);
        check("reset_turn_right", int'(turn_right), 0);
        check("reset_turn_left", int'(turn_left), 0);
        check("reset_pending", int'(pending_count), 0);
        check("reset_overflow", int'(overflow), 0);
        reset = 1'b0;
        cycles(2);

        // Table-driven press/tik scenarios.
        for (int v = 0; v < 6; v++) begin
            begin_run();
            base_r = n_r;
            base_l = n_l;
            for (int i = 0; i < vecs[v].n_right; i++) press(1'b1);
            for (int i = 0; i < vecs[v].n_left; i++) press(1'b0);
            check($sformatf("vec%0d_pending", v), int'(pending_count), vecs[v].exp_pend);
            check($sformatf("vec%0d_overflow", v), int'(overflow), vecs[v].exp_ovf);
            for (int i = 0; i < vecs[v].n_tik; i++) tik();
            cycles(2);
            check($sformatf("vec%0d_rights", v), n_r - base_r, vecs[v].exp_r);
            check($sformatf("vec%0d_lefts", v), n_l - base_l, vecs[v].exp_l);
            check($sformatf("vec%0d_pending_after", v), int'(pending_count), vecs[v].exp_pend_after);
            check($sformatf("vec%0d_overflow_after", v), int'(overflow), vecs[v].exp_ovf);
        end
        do_sync_reset();
        check("sync_reset_clears_overflow", int'(overflow), 0);
        check("sync_reset_flushes", int'(pending_count), 0);

        // Bouncing key: only the final stable press counts.
        begin_run();
        pend_peak = 0;
        base_r = n_r;
        for (int i = 0; i < 8; i++) begin
            key_right_n = ~key_right_n;
            cycles(5);
        end
        key_right_n = 1'b0;
        cycles(30);
        key_right_n = 1'b1;
        cycles(30);
        check("bounce_peak", pend_peak, 1);
        tik();
        tik();
        check("bounce_rights", n_r - base_r, 1);

        // Full FIFO (R,L) with a left press landing on the same edge as a pop.
        begin_run();
        press(1'b1);
        press(1'b0);
        check("full_pending", int'(pending_count), 2);
        base_r = n_r;
        base_l = n_l;
        key_left_n = 1'b0;
        repeat (18) step();
        game_tik = 1'b1;
        step();
        game_tik = 1'b0;
        check("poppush_turn_right", int'(turn_right), 1);
        check("poppush_pending", int'(pending_count), 2);
        check("poppush_overflow", int'(overflow), 0);
        cycles(10);
        key_left_n = 1'b1;
        cycles(25);
        tik();
        tik();
        check("poppush_rights", n_r - base_r, 1);
        check("poppush_lefts", n_l - base_l, 2);
        check("poppush_drained", int'(pending_count), 0);

        // Both keys pressed together are discarded.
        begin_run();
        key_right_n = 1'b0;
        key_left_n  = 1'b0;
        cycles(25);
        key_right_n = 1'b1;
        key_left_n  = 1'b1;
        cycles(25);
        check("both_pending", int'(pending_count), 0);
        check("both_overflow", int'(overflow), 0);

        // Gating by start/game_over and HALT holding contents.
        start = 1'b0;
        game_over = 1'b0;
        do_sync_reset();
        press(1'b1);
        check("idle_no_enqueue", int'(pending_count), 0);
        start = 1'b1;
        game_over = 1'b1;
        cycles(2);
        press(1'b0);
        check("gameover_idle_no_enqueue", int'(pending_count), 0);
        game_over = 1'b0;
        cycles(2);
        press(1'b1);
        check("run_enqueue", int'(pending_count), 1);
        game_over = 1'b1;
        cycles(2);
        press(1'b0);
        check("halt_no_enqueue", int'(pending_count), 1);
        base_r = n_r;
        base_l = n_l;
        tik();
        check("halt_no_pop", int'(pending_count), 1);
        game_over = 1'b0;
        cycles(2);
        check("halt_holds", int'(pending_count), 1);
        do_sync_reset();
        step();
        check("halt_flushed", int'(pending_count), 0);
        tik();
        check("halt_no_pulses", (n_r - base_r) + (n_l - base_l), 0);

        // Asynchronous reset mid-debounce with live outputs.
        begin_run();
        press(1'b1);
        press(1'b1);
        press(1'b1);
        key_left_n = 1'b0;
        cycles(8);
        game_tik = 1'b1;
        step();
        game_tik = 1'b0;
        check("pre_reset_turn_right", int'(turn_right), 1);
        check("pre_reset_pending", int'(pending_count), 1);
        #2 reset = 1'b1;
        #1;
        check("async_turn_right", int'(turn_right), 0);
        check("async_turn_left", int'(turn_left), 0);
        check("async_pending", int'(pending_count), 0);
        check("async_overflow", int'(overflow), 0);
        key_left_n = 1'b1;
        step();
        reset = 1'b0;
        base_r = n_r;
        base_l = n_l;
        cycles(3);
        tik();
        tik();
        check("post_reset_no_pulse", (n_r - base_r) + (n_l - base_l), 0);

        // Random stimulus against the reference model.
        begin_run();
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 29) == 0) key_right_n = ~key_right_n;
            if ($urandom_range(0, 29) == 0) key_left_n = ~key_left_n;
            game_tik   = ($urandom_range(0, 15) == 0);
            sync_reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 249) == 0) game_over = ~game_over;
            if ($urandom_range(0, 299) == 0) start = ~start;
            step();
        end
        game_tik = 1'b0;
        sync_reset = 1'b0;
        key_right_n = 1'b1;
        key_left_n = 1'b1;
        cycles(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/turn_request_scheduler.md
Name: turn_request_scheduler

Overview:
- Sits between the raw push-buttons (KEY2 right, KEY3 left) and snake_game_fsm.
- Synchronises and debounces both keys, then converts each press into one turn request.
- Buffers requests in a small FIFO and releases at most one per game_tik, as a single-cycle pulse.
- Result: quick double presses between moves are never lost or merged, and bounce never produces extra turns.

Parameters:
- DEBOUNCE_BIT, 18, width of the debounce counter; a level must hold stable for 2^DEBOUNCE_BIT clock_25 cycles (about 10.5 ms) before it is accepted.
- FIFO_DEPTH_BIT, 1, log2 of FIFO depth; default depth is 2.

Ports:
- clock_25  input  1  25 MHz pixel/system clock.
- reset  input  1  asynchronous, active-high reset.
- key_right_n  input  1  raw KEY2, active-low, asynchronous to clock_25.
- key_left_n  input  1  raw KEY3, active-low, asynchronous to clock_25.
- game_tik  input  1  one-cycle move strobe from game_delay_fsm.
- start  input  1  game running level from snake_game_fsm.
- game_over  input  1  game-over level from snake_game_fsm.
- sync_reset  input  1  one-cycle synchronous restart strobe.
- turn_right  output  1  one-cycle request to turn right.
- turn_left  output  1  one-cycle request to turn left.
- pending_count  output  FIFO_DEPTH_BIT+1  number of queued turns.
- overflow  output  1  sticky flag: a press was dropped because the FIFO was full.

Behaviour:
- Reset values (reset=1, asynchronous):
  - all outputs 0, FIFO empty, state IDLE;
  - debounced key states = released (1), synchronisers = 1, counters = 0.
- Synchroniser: two flip-flops per key; the debouncer only sees the second stage.
- Debouncer, per key:
  - counter clears whenever the synced value equals the debounced state;
  - otherwise it increments; when it reaches 2^DEBOUNCE_BIT-1 the debounced state takes the synced value and the counter clears;
  - press event = debounced 1->0 transition, one cycle wide; release produces no event.
- Key-to-event latency is 2 + 2^DEBOUNCE_BIT cycles from a stable key edge.
- Same-cycle press events on both keys: both discarded, no FIFO write, overflow unchanged.
- State machine (3 states):
  - IDLE: events discarded; go to RUN when start=1 and game_over=0.
  - RUN: events enqueued; go to HALT when game_over=1.
  - HALT: events discarded, no dequeue, FIFO contents held; go to IDLE on sync_reset.
  - sync_reset in any state: next state IDLE, FIFO flushed, overflow=0, turn_* = 0. Debouncers are not touched.
  - sync_reset has priority over every other event in that cycle.
- FIFO entry is 1 bit: 1 = right, 0 = left. Pointers are FIFO_DEPTH_BIT+1 bits wide; full/empty are decided by the MSB compare.
- Dequeue:
  - occurs in RUN on game_tik=1 with FIFO non-empty;
  - the popped entry drives turn_right or turn_left high for exactly the next cycle (registered, latency 1);
  - at most one turn per game_tik;
  - game_tik with empty FIFO gives no pulse.
- Enqueue/dequeue boundaries:
  - pop and push in the same cycle: pop is evaluated first, so a push into a full FIFO is accepted; pending_count is unchanged.
  - push with FIFO empty and game_tik in the same cycle: no bypass; the entry issues on the next game_tik.
  - push while full with no pop: entry dropped, overflow set to 1 and held until sync_reset or reset.
- pending_count is registered and reflects FIFO occupancy after the current cycle's push/pop.
- turn_right and turn_left are never high together.

Decomposition:
- Shared package, snake_pkg:
  - state encoding TS_IDLE=2'd0, TS_RUN=2'd1, TS_HALT=2'd2;
  - direction codes TURN_LEFT=1'b0, TURN_RIGHT=1'b1;
  - default DEBOUNCE_BIT.
- One sub-module, key_debouncer (synchroniser + counter + press-event output), instantiated twice.
- FIFO and FSM are kept inline.

Test Plan (DEBOUNCE_BIT=4, i.e. 16-cycle debounce):
- Debounce: toggle key_right_n every 5 cycles for 40 cycles, then hold at 0; with start=1, game_tik every 100 cycles -> exactly one turn_right pulse, pending_count peaks at 1.
- Double press: right press then left press 30 cycles apart, both before one game_tik -> pending_count=2; the first game_tik gives turn_right one cycle later, the next game_tik gives turn_left.
- Overflow: three right presses with no game_tik -> pending_count=2, overflow=1; after two game_tik, two turn_right pulses, overflow still 1; sync_reset -> overflow=0.
- Full + simultaneous pop/push: FIFO full (R,L); a left press event coincides with game_tik -> turn_right pulses, pending_count stays 2, later pops give L, L.
- Gating: presses while start=0, and while game_over=1 -> no enqueue, pending_count=0, no turn pulses; HALT holds contents until sync_reset flushes them.
- Async reset: assert reset mid-debounce with FIFO holding 1 entry -> all outputs 0 immediately (before the next clock edge); after release, no spurious pulse on game_tik.
